// File: rtl/mcash_xbar_grant_monitor.sv
// -----------------------------------------------------------------------------
// mcash_xbar_grant_monitor
//
// Watches every bank arbiter of the mcash cross-bar core. It does four things:
//   - keeps a saturating grant counter for each (bank, channel) pair
//   - streams timestamped grant snapshots through a valid/ready trace FIFO
//   - raises sticky starvation flags for each (bank, channel) pair
//   - raises a sticky flag when a bank shows more than one grant in a cycle
//
// Optional feature macro: MCASH_XBAR_MON_STARVE_EN
//   defined     : wait counters, starve_flag and the starvation term of
//                 mon_irq are built.
//   not defined : no wait counters, starve_flag is tied to 0, and mon_irq is
//                 the registered grant_err only.
//
// Ports
//   clk, rst_n     : clock and asynchronous active-low reset
//   mon_en         : enables tracing and grant counting
//   clr            : synchronous clear of the grant counters, the drop count,
//                    the wait counters and the sticky flags
//   bank_ch_req    : request bits, index b*NUM_CH+c
//   bank_ch_grant  : grant bits, same indexing as bank_ch_req
//   bank_entry_id  : entry ID per bank, valid together with its grant
//   trc_valid      : trace FIFO output valid (FIFO is non-empty)
//   trc_ready      : trace consumer ready; a pop is trc_valid && trc_ready
//   trc_data       : {timestamp, grant vector, entry IDs}, MSB to LSB
//   trc_drop_cnt   : number of snapshots lost to a full FIFO (saturating)
//   cnt_sel        : selects the grant counter to read
//   cnt_rd_data    : registered value of the selected grant counter
//   starve_flag    : sticky starvation flags, one per (bank, channel)
//   grant_err      : sticky flag, set when a bank has >1 grant in a cycle
//   mon_irq        : registered OR of starve_flag and grant_err
// -----------------------------------------------------------------------------
module mcash_xbar_grant_monitor #(
    parameter int NUM_CH       = 3,
    parameter int NUM_BANK     = 4,
    parameter int ENTRY_ID_W   = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int TS_W         = 16,
    parameter int CNT_W        = 16,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               mon_en,
    input  logic                                               clr,
    input  logic [NUM_BANK*NUM_CH-1:0]                         bank_ch_req,
    input  logic [NUM_BANK*NUM_CH-1:0]                         bank_ch_grant,
    input  logic [NUM_BANK*ENTRY_ID_W-1:0]                     bank_entry_id,
    output logic                                               trc_valid,
    input  logic                                               trc_ready,
    output logic [TS_W+NUM_BANK*NUM_CH+NUM_BANK*ENTRY_ID_W-1:0] trc_data,
    output logic [CNT_W-1:0]                                   trc_drop_cnt,
    input  logic [$clog2(NUM_BANK*NUM_CH):0]                   cnt_sel,
    output logic [CNT_W-1:0]                                   cnt_rd_data,
    output logic [NUM_BANK*NUM_CH-1:0]                         starve_flag,
    output logic                                               grant_err,
    output logic                                               mon_irq
);

    localparam int NP   = NUM_BANK * NUM_CH;
    localparam int DW   = TS_W + NP + NUM_BANK * ENTRY_ID_W;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int SELW = $clog2(NP) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // -------------------------------------------------------------------------
    // Free-running timestamp
    // -------------------------------------------------------------------------
    logic [TS_W-1:0] ts_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + TS_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Snapshot capture stage. The snapshot is registered first and written
    // into the FIFO on the following edge. This keeps the tap off the arbiter
    // timing paths, and it is why trc_valid rises one edge after the grant.
    // -------------------------------------------------------------------------
    logic          snap_vld_reg;
    logic [DW-1:0] snap_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_vld_reg  <= 1'b0;
            snap_data_reg <= '0;
        end else begin
            snap_vld_reg  <= mon_en && (|bank_ch_grant);
            snap_data_reg <= {ts_reg, bank_ch_grant, bank_entry_id};
        end
    end

    // -------------------------------------------------------------------------
    // Trace FIFO: array storage with a registered head. trc_data_reg always
    // holds the entry at the next read pointer. A write into an empty FIFO
    // bypasses straight into the head register.
    // -------------------------------------------------------------------------
    logic [DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          trc_valid_reg;
    logic [DW-1:0] trc_data_reg;
    logic [DW-1:0] head_next;
    logic          pop;
    logic          fifo_full;
    logic          push_ok;
    logic          push_drop;

    always_comb begin
        pop         = trc_valid_reg && trc_ready;
        fifo_full   = (count_reg == (AW+1)'(FIFO_DEPTH));
        // A full FIFO still accepts a push when the head leaves in the same cycle
        push_ok     = snap_vld_reg && (!fifo_full || pop);
        push_drop   = snap_vld_reg && fifo_full && !pop;
        rd_ptr_next = rd_ptr_reg + AW'(pop);
        count_next  = count_reg + (AW+1)'(push_ok) - (AW+1)'(pop);
        // The write slot can equal the next head slot only when the FIFO is
        // about to be empty. In that case the entry being written becomes the
        // new head.
        if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
            head_next = snap_data_reg;
        end else begin
            head_next = fifo_mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= snap_data_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            trc_valid_reg <= 1'b0;
            trc_data_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            trc_valid_reg <= (count_next != '0);
            if (count_next != '0) begin
                trc_data_reg <= head_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Drop counter
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] drop_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else if (clr) begin
            drop_cnt_reg <= '0;
        end else if (push_drop && (drop_cnt_reg != CNT_MAX)) begin
            drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Per-pair grant counters and the registered read port
    // -------------------------------------------------------------------------
    logic [NP*CNT_W-1:0] cnt_flat;
    logic [CNT_W-1:0]    rd_sel_val;
    logic [CNT_W-1:0]    cnt_rd_reg;

    for (genvar gi = 0; gi < NP; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (clr) begin
                cnt_reg <= '0;
            end else if (mon_en && bank_ch_grant[gi] && (cnt_reg != CNT_MAX)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end

        assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
    end

    // Out-of-range selects match no entry and so read 0
    always_comb begin
        rd_sel_val = '0;
        for (int i = 0; i < NP; i++) begin
            if (cnt_sel == SELW'(i)) begin
                rd_sel_val = cnt_flat[i*CNT_W +: CNT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_rd_reg <= '0;
        end else begin
            cnt_rd_reg <= rd_sel_val;
        end
    end

    // -------------------------------------------------------------------------
    // Multi-grant detection. g & (g - 1) is non-zero exactly when more than
    // one bit of g is set.
    // -------------------------------------------------------------------------
    logic [NUM_BANK-1:0] bank_multi;
    logic                grant_err_reg;

    for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank
        logic [NUM_CH-1:0] bank_grant;
        assign bank_grant     = bank_ch_grant[gi*NUM_CH +: NUM_CH];
        assign bank_multi[gi] = |(bank_grant & (bank_grant - NUM_CH'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_err_reg <= 1'b0;
        end else if (clr) begin
            grant_err_reg <= 1'b0;
        end else if (|bank_multi) begin
            grant_err_reg <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Starvation tracking and interrupt
    // -------------------------------------------------------------------------
    logic [NP-1:0] starve_vec;
    logic          mon_irq_reg;

`ifdef MCASH_XBAR_MON_STARVE_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    for (genvar gi = 0; gi < NP; gi++) begin : g_starve
        logic [WAIT_W-1:0] wait_reg;
        logic              flag_reg;
        logic              starving;

        assign starving = bank_ch_req[gi] && !bank_ch_grant[gi];

        // The wait count stops at the limit. The flag is set on the edge
        // that brings the count to the limit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wait_reg <= '0;
                flag_reg <= 1'b0;
            end else if (clr) begin
                wait_reg <= '0;
                flag_reg <= 1'b0;
            end else if (starving) begin
                if (wait_reg != WAIT_W'(STARVE_LIMIT)) begin
                    wait_reg <= wait_reg + WAIT_W'(1);
                end
                if (wait_reg == WAIT_W'(STARVE_LIMIT - 1)) begin
                    flag_reg <= 1'b1;
                end
            end else begin
                wait_reg <= '0;
            end
        end

        assign starve_vec[gi] = flag_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_irq_reg <= 1'b0;
        end else begin
            mon_irq_reg <= (|starve_vec) | grant_err_reg;
        end
    end
`else
    // No starvation logic in this build. The request bits and the limit are
    // intentionally unused here.
    logic starve_unused;
    assign starve_unused = (^bank_ch_req) ^ (STARVE_LIMIT == 0);
    assign starve_vec    = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_irq_reg <= 1'b0;
        end else begin
            mon_irq_reg <= grant_err_reg;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign trc_valid    = trc_valid_reg;
    assign trc_data     = trc_data_reg;
    assign trc_drop_cnt = drop_cnt_reg;
    assign cnt_rd_data  = cnt_rd_reg;
    assign starve_flag  = starve_vec;
    assign grant_err    = grant_err_reg;
    assign mon_irq      = mon_irq_reg;

endmodule

// File: tb/tb_mcash_xbar_grant_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for mcash_xbar_grant_monitor.
//
// The DUT is built with CNT_W=4 so that counter saturation can be reached
// quickly. Every clock edge goes through tick(). tick() advances a
// transaction-level reference model: a queue of trace entries, integer grant
// counters, integer wait counters and the sticky flags. Each test task then
// compares the DUT outputs with that model and with hand-derived constants.
// -----------------------------------------------------------------------------
module tb_mcash_xbar_grant_monitor;

    localparam int NC    = 3;
    localparam int NB    = 4;
    localparam int IDW   = 4;
    localparam int DEPTH = 16;
    localparam int TSW   = 16;
    localparam int CW    = 4;
    localparam int LIM   = 64;
    localparam int NP    = NB * NC;
    localparam int DW    = TSW + NP + NB * IDW;
    localparam int SELW  = $clog2(NP) + 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mon_en = 1'b0;
    logic            clr = 1'b0;
    logic            trc_ready = 1'b0;
    logic [NP-1:0]   bank_ch_req = '0;
    logic [NP-1:0]   bank_ch_grant = '0;
    logic [NB*IDW-1:0] bank_entry_id = '0;
    logic [SELW-1:0] cnt_sel = '0;
    logic            trc_valid;
    logic [DW-1:0]   trc_data;
    logic [CW-1:0]   trc_drop_cnt;
    logic [CW-1:0]   cnt_rd_data;
    logic [NP-1:0]   starve_flag;
    logic            grant_err;
    logic            mon_irq;

    mcash_xbar_grant_monitor #(
        .NUM_CH(NC), .NUM_BANK(NB), .ENTRY_ID_W(IDW), .FIFO_DEPTH(DEPTH),
        .TS_W(TSW), .CNT_W(CW), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .clr(clr),
        .bank_ch_req(bank_ch_req), .bank_ch_grant(bank_ch_grant),
        .bank_entry_id(bank_entry_id), .trc_valid(trc_valid),
        .trc_ready(trc_ready), .trc_data(trc_data),
        .trc_drop_cnt(trc_drop_cnt), .cnt_sel(cnt_sel),
        .cnt_rd_data(cnt_rd_data), .starve_flag(starve_flag),
        .grant_err(grant_err), .mon_irq(mon_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model state ----------------
    logic [DW-1:0]  exp_q[$];
    logic           pend_v;
    logic [DW-1:0]  pend_d;
    logic [TSW-1:0] m_ts;
    int             m_cnt[NP];
    int             m_wait[NP];
    int             m_drop;
    int             m_rd;
    logic [NP-1:0]  m_starve;
    logic           m_err;
    logic           m_irq;
    logic [NP-1:0]  exp_starve;

    task automatic model_reset();
        exp_q.delete();
        pend_v = 1'b0;
        pend_d = '0;
        m_ts   = '0;
        for (int i = 0; i < NP; i++) begin
            m_cnt[i]  = 0;
            m_wait[i] = 0;
        end
        m_drop     = 0;
        m_rd       = 0;
        m_starve   = '0;
        m_err      = 1'b0;
        m_irq      = 1'b0;
        exp_starve = '0;
    endtask

    // One clock edge. The inputs in force at the edge drive the model update.
    // The task returns 1 time unit after the edge.
    task automatic tick();
        logic [NP-1:0]     g;
        logic [NP-1:0]     r;
        logic [NB*IDW-1:0] ids;
        logic              en;
        logic              cl;
        logic              rdy;
        logic [SELW-1:0]   sel;
        int                sz;
        bit                pop;
        bit                multi;
        g   = bank_ch_grant;
        r   = bank_ch_req;
        ids = bank_entry_id;
        en  = mon_en;
        cl  = clr;
        rdy = trc_ready;
        sel = cnt_sel;
        @(posedge clk);
        #1;
        sz  = exp_q.size();
        pop = (sz > 0) && rdy;
        if (int'(sel) < NP) m_rd = m_cnt[int'(sel)];
        else m_rd = 0;
`ifdef MCASH_XBAR_MON_STARVE_EN
        m_irq = (m_starve != '0) || m_err;
`else
        m_irq = m_err;
`endif
        if (pop) void'(exp_q.pop_front());
        if (pend_v) begin
            if (sz < DEPTH || pop) exp_q.push_back(pend_d);
            else if (m_drop < CMAX) m_drop++;
        end
        if (cl) m_drop = 0;
        pend_v = en && (g != '0);
        pend_d = {m_ts, g, ids};
        m_ts   = m_ts + 1'b1;
        multi  = 0;
        for (int b = 0; b < NB; b++) begin
            if ($countones(g[b*NC +: NC]) >= 2) multi = 1;
        end
        for (int i = 0; i < NP; i++) begin
            if (cl) m_cnt[i] = 0;
            else if (en && g[i] && m_cnt[i] < CMAX) m_cnt[i]++;
        end
        if (cl) m_err = 1'b0;
        else if (multi) m_err = 1'b1;
        for (int i = 0; i < NP; i++) begin
            if (cl) begin
                m_wait[i]   = 0;
                m_starve[i] = 1'b0;
            end else if (r[i] && !g[i]) begin
                if (m_wait[i] < LIM) m_wait[i]++;
                if (m_wait[i] == LIM) m_starve[i] = 1'b1;
            end else begin
                m_wait[i] = 0;
            end
        end
`ifdef MCASH_XBAR_MON_STARVE_EN
        exp_starve = m_starve;
`else
        exp_starve = '0;
`endif
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_checks++;
        if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", trc_valid); end
        n_checks++;
        if (trc_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", trc_data); end
        n_checks++;
        if (trc_drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", trc_drop_cnt); end
        n_checks++;
        if (cnt_rd_data !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt_rd_data); end
        n_checks++;
        if ({starve_flag, grant_err, mon_irq} !== '0) begin
            n_fail++; $display("FAIL reset_flags: got %h/%b/%b expected 0", starve_flag, grant_err, mon_irq);
        end
        $display("test_reset: done");
    endtask

    task automatic test_first_snapshot();
        logic [DW-1:0] exp_c;
        exp_c = {16'd10, 12'h002, 16'h0005};
        repeat (10) tick();
        mon_en        = 1'b1;
        bank_ch_grant = 12'h002;
        bank_entry_id = 16'h0005;
        tick();
        n_checks++;
        if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL snap_latency: got valid %b expected 0", trc_valid); end
        bank_ch_grant = '0;
        tick();
        n_checks++;
        if (trc_valid !== 1'b1) begin n_fail++; $display("FAIL snap_valid: got %b expected 1", trc_valid); end
        n_checks++;
        if (trc_data !== exp_c) begin n_fail++; $display("FAIL snap_data: got %h expected %h", trc_data, exp_c); end
        n_checks++;
        if (exp_q.size() == 0 || trc_data !== exp_q[0]) begin
            n_fail++; $display("FAIL snap_model: got %h model queue size %0d", trc_data, exp_q.size());
        end
        $display("test_first_snapshot: entry %h", trc_data);
    endtask

    task automatic test_fifo_full();
        trc_ready = 1'b1;
        tick();
        trc_ready = 1'b0;
        do_clr();
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bank_ch_grant = NP'(1) << $urandom_range(0, NP - 1);
            bank_entry_id = NB*IDW'($urandom);
            tick();
        end
        bank_ch_grant = '0;
        tick();
        n_checks++;
        if (trc_drop_cnt !== 4'd4) begin n_fail++; $display("FAIL fifo_drop: got %0d expected 4", trc_drop_cnt); end
        // full FIFO: a push and a pop in the same cycle must not drop
        bank_ch_grant = 12'h001;
        tick();
        trc_ready     = 1'b1;
        bank_ch_grant = '0;
        tick();
        n_checks++;
        if (trc_drop_cnt !== CW'(m_drop) || trc_drop_cnt !== 4'd4) begin
            n_fail++; $display("FAIL fifo_pop_push_drop: got %0d expected 4", trc_drop_cnt);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (trc_valid !== 1'b1) begin n_fail++; $display("FAIL fifo_drain_valid[%0d]: got %b expected 1", i, trc_valid); end
            n_checks++;
            if (exp_q.size() == 0 || trc_data !== exp_q[0]) begin
                n_fail++; $display("FAIL fifo_drain_data[%0d]: got %h model size %0d", i, trc_data, exp_q.size());
            end
            if (i == DEPTH - 1) begin
                n_checks++;
                if (trc_data[DW-TSW-1 -: NP] !== 12'h001) begin
                    n_fail++; $display("FAIL fifo_last_grant: got %h expected 001", trc_data[DW-TSW-1 -: NP]);
                end
            end
            $display("pop %0d: ts=%0d grant=%h ids=%h", i, trc_data[DW-1 -: TSW], trc_data[DW-TSW-1 -: NP], trc_data[NB*IDW-1:0]);
            tick();
        end
        n_checks++;
        if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_empty: got %b expected 0", trc_valid); end
    endtask

    task automatic test_counter();
        trc_ready = 1'b1;
        mon_en    = 1'b1;
        do_clr();
        bank_ch_grant = 12'h100;
        repeat (7) tick();
        bank_ch_grant = '0;
        cnt_sel = 5'd8;
        tick();
        tick();
        n_checks++;
        if (cnt_rd_data !== 4'd7 || cnt_rd_data !== CW'(m_rd)) begin
            n_fail++; $display("FAIL cnt_7: got %0d expected 7", cnt_rd_data);
        end
        cnt_sel = 5'd15;
        tick();
        n_checks++;
        if (cnt_rd_data !== 4'd0) begin n_fail++; $display("FAIL cnt_sel15: got %0d expected 0", cnt_rd_data); end
        cnt_sel = 5'd8;
        tick();
        n_checks++;
        if (cnt_rd_data !== 4'd7) begin n_fail++; $display("FAIL cnt_sel_back: got %0d expected 7", cnt_rd_data); end
        cnt_sel = 5'd12;
        tick();
        n_checks++;
        if (cnt_rd_data !== 4'd0) begin n_fail++; $display("FAIL cnt_sel12: got %0d expected 0", cnt_rd_data); end
        do_clr();
        cnt_sel = 5'd8;
        bank_ch_grant = 12'h100;
        repeat (20) tick();
        bank_ch_grant = '0;
        tick();
        tick();
        n_checks++;
        if (cnt_rd_data !== 4'd15) begin n_fail++; $display("FAIL cnt_sat: got %0d expected 15", cnt_rd_data); end
        $display("test_counter: saturated read %0d", cnt_rd_data);
    endtask

`ifdef MCASH_XBAR_MON_STARVE_EN
    task automatic test_starve();
        mon_en        = 1'b0;
        bank_ch_grant = '0;
        do_clr();
        bank_ch_req = 12'h008;
        repeat (LIM - 1) tick();
        n_checks++;
        if (starve_flag !== 12'h000) begin n_fail++; $display("FAIL starve_early: got %h expected 000", starve_flag); end
        tick();
        n_checks++;
        if (starve_flag !== 12'h008 || starve_flag !== exp_starve) begin
            n_fail++; $display("FAIL starve_set: got %h expected 008", starve_flag);
        end
        n_checks++;
        if (mon_irq !== 1'b0) begin n_fail++; $display("FAIL starve_irq_early: got %b expected 0", mon_irq); end
        tick();
        n_checks++;
        if (mon_irq !== 1'b1) begin n_fail++; $display("FAIL starve_irq: got %b expected 1", mon_irq); end
        bank_ch_req = '0;
        do_clr();
        n_checks++;
        if (starve_flag !== 12'h000) begin n_fail++; $display("FAIL starve_clr: got %h expected 000", starve_flag); end
        bank_ch_req = 12'h008;
        repeat (LIM - 2) tick();
        bank_ch_grant = 12'h008;
        tick();
        bank_ch_grant = '0;
        repeat (10) tick();
        n_checks++;
        if (starve_flag !== 12'h000) begin n_fail++; $display("FAIL starve_grant63: got %h expected 000", starve_flag); end
        bank_ch_req = '0;
        do_clr();
        $display("test_starve: done");
    endtask
`else
    task automatic test_no_starve();
        mon_en        = 1'b0;
        bank_ch_grant = '0;
        do_clr();
        bank_ch_req = 12'h008;
        repeat (200) tick();
        n_checks++;
        if (starve_flag !== 12'h000) begin n_fail++; $display("FAIL nostarve_flag: got %h expected 000", starve_flag); end
        n_checks++;
        if (mon_irq !== 1'b0) begin n_fail++; $display("FAIL nostarve_irq: got %b expected 0", mon_irq); end
        bank_ch_req = '0;
        $display("test_no_starve: done");
    endtask
`endif

    task automatic test_grant_err();
        mon_en    = 1'b1;
        trc_ready = 1'b1;
        do_clr();
        bank_ch_grant = 12'ha00;
        tick();
        n_checks++;
        if (grant_err !== 1'b1) begin n_fail++; $display("FAIL gerr_set: got %b expected 1", grant_err); end
        bank_ch_grant = '0;
        tick();
        n_checks++;
        if (grant_err !== 1'b1) begin n_fail++; $display("FAIL gerr_sticky: got %b expected 1", grant_err); end
        n_checks++;
        if (mon_irq !== 1'b1) begin n_fail++; $display("FAIL gerr_irq: got %b expected 1", mon_irq); end
        do_clr();
        n_checks++;
        if (grant_err !== 1'b0) begin n_fail++; $display("FAIL gerr_clr: got %b expected 0", grant_err); end
        // clr wins over a same-cycle count increment and a same-cycle error set
        clr           = 1'b1;
        bank_ch_grant = 12'hb00;
        cnt_sel       = 5'd8;
        tick();
        clr           = 1'b0;
        bank_ch_grant = '0;
        n_checks++;
        if (grant_err !== 1'b0) begin n_fail++; $display("FAIL gerr_clr_prio: got %b expected 0", grant_err); end
        tick();
        tick();
        n_checks++;
        if (cnt_rd_data !== 4'd0) begin n_fail++; $display("FAIL cnt_clr_prio: got %0d expected 0", cnt_rd_data); end
        n_checks++;
        if (mon_irq !== 1'b0) begin n_fail++; $display("FAIL gerr_irq_clr: got %b expected 0", mon_irq); end
        $display("test_grant_err: done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            mon_en        = ($urandom_range(0, 3) != 0);
            trc_ready     = $urandom_range(0, 1) == 1;
            clr           = ($urandom_range(0, 63) == 0);
            bank_ch_req   = NP'($urandom);
            bank_ch_grant = NP'($urandom & $urandom & $urandom) & bank_ch_req;
            bank_entry_id = NB*IDW'($urandom);
            cnt_sel       = SELW'($urandom_range(0, 15));
            if (trc_valid && trc_ready) begin
                $display("rand pop: ts=%0d grant=%h ids=%h", trc_data[DW-1 -: TSW], trc_data[DW-TSW-1 -: NP], trc_data[NB*IDW-1:0]);
            end
            tick();
            n_checks++;
            if (trc_valid !== (exp_q.size() > 0)) begin
                n_fail++; $display("FAIL rand_valid[%0d]: got %b model size %0d", c, trc_valid, exp_q.size());
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                if (trc_data !== exp_q[0]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", c, trc_data, exp_q[0]); end
            end
            n_checks++;
            if (trc_drop_cnt !== CW'(m_drop)) begin n_fail++; $display("FAIL rand_drop[%0d]: got %0d expected %0d", c, trc_drop_cnt, m_drop); end
            n_checks++;
            if (cnt_rd_data !== CW'(m_rd)) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", c, cnt_rd_data, m_rd); end
            n_checks++;
            if (starve_flag !== exp_starve) begin n_fail++; $display("FAIL rand_starve[%0d]: got %h expected %h", c, starve_flag, exp_starve); end
            n_checks++;
            if (grant_err !== m_err) begin n_fail++; $display("FAIL rand_gerr[%0d]: got %b expected %b", c, grant_err, m_err); end
            n_checks++;
            if (mon_irq !== m_irq) begin n_fail++; $display("FAIL rand_irq[%0d]: got %b expected %b", c, mon_irq, m_irq); end
        end
        clr = 1'b0;
        $display("test_random: done");
    endtask

    task automatic test_async_reset();
        mon_en        = 1'b1;
        trc_ready     = 1'b0;
        cnt_sel       = 5'd9;
        bank_ch_grant = 12'ha00;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (trc_valid !== 1'b0 || trc_data !== '0) begin
            n_fail++; $display("FAIL areset_fifo: got valid %b data %h expected 0", trc_valid, trc_data);
        end
        n_checks++;
        if ({trc_drop_cnt, cnt_rd_data, starve_flag, grant_err, mon_irq} !== '0) begin
            n_fail++; $display("FAIL areset_state: got %h/%h/%h/%b/%b expected 0", trc_drop_cnt, cnt_rd_data, starve_flag, grant_err, mon_irq);
        end
        bank_ch_grant = '0;
        bank_ch_req   = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL areset_lost: got %b expected 0", trc_valid); end
        bank_ch_grant = 12'h040;
        tick();
        bank_ch_grant = '0;
        tick();
        n_checks++;
        if (trc_valid !== 1'b1 || trc_data[DW-1 -: TSW] !== 16'd3) begin
            n_fail++; $display("FAIL areset_ts: got valid %b ts %0d expected 1/3", trc_valid, trc_data[DW-1 -: TSW]);
        end
        $display("test_async_reset: done");
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_first_snapshot();
        test_fifo_full();
        test_counter();
`ifdef MCASH_XBAR_MON_STARVE_EN
        test_starve();
`else
        test_no_starve();
`endif
        test_grant_err();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
